// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared constants and types for the stream_demux4 slice.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int NPORTS = 4;
    localparam int SELW   = 2;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_EMPTY = 2'd0;
    localparam cnt_t CNT_FULL  = 2'd2;

    // A 2-entry slot is full when it holds both entries.
    function automatic logic slot_full(input cnt_t c);
        return (c == CNT_FULL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : 2-entry valid/ready FIFO used as one output port buffer.
//               Head data is registered; no bypass from push data to output.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
    import stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    cnt_t             r_count;
    logic             w_pop;

    assign o_valid = (r_count != CNT_EMPTY);
    assign o_full  = slot_full(r_count);
    assign o_data  = r_data[r_rd_ptr];
    assign w_pop   = o_valid & i_ready;

    // Buffer storage, pointers and occupancy; flush clears state but keeps data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= CNT_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                r_data[k] <= '0;
            end
        end else if (flush) begin
            r_count  <= CNT_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr] <= i_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_demux4.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux4
// Description : Routes one valid/ready stream to one of four buffered output
//               streams. in_ready depends only on in_sel, flush and registered
//               occupancy, never on any out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux4
    import stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SELW-1:0]   in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic [NPORTS-1:0] out_valid,
    input  logic [NPORTS-1:0] out_ready,
    output logic [WIDTH-1:0]  dout0,
    output logic [WIDTH-1:0]  dout1,
    output logic [WIDTH-1:0]  dout2,
    output logic [WIDTH-1:0]  dout3,
    output logic              busy
);

    logic [NPORTS-1:0] w_full;
    logic [NPORTS-1:0] w_push;
    logic [WIDTH-1:0]  w_dout [NPORTS];
    logic              w_accept;

    // Selected-port full flag gates the producer; flush blocks all pushes.
    assign in_ready = ~w_full[in_sel] & ~flush;
    assign w_accept = in_valid & in_ready;
    assign busy     = |out_valid;

    assign dout0 = w_dout[0];
    assign dout1 = w_dout[1];
    assign dout2 = w_dout[2];
    assign dout3 = w_dout[3];

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_slot
            assign w_push[gi] = w_accept & (in_sel == gi[SELW-1:0]);

            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk     (clk),
                .reset_n (reset_n),
                .flush   (flush),
                .i_push  (w_push[gi]),
                .i_data  (in_data),
                .i_ready (out_ready[gi]),
                .o_valid (out_valid[gi]),
                .o_full  (w_full[gi]),
                .o_data  (w_dout[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stream_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux4
// Description : Directed and randomized self-checking bench for stream_demux4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux4;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] dout0, dout1, dout2, dout3;
    logic       busy;
    logic [7:0] dout_a [4];

    int checks = 0;
    int errors = 0;

    assign dout_a[0] = dout0;
    assign dout_a[1] = dout1;
    assign dout_a[2] = dout2;
    assign dout_a[3] = dout3;

    stream_demux4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout0     (dout0),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 4'hF;
        repeat (3) tick();
        out_ready = 4'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd2;
        in_data = 8'hA5; out_ready = 4'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
            checks++;
            if (out_valid !== 4'b0000 || busy !== 1'b0) begin
                errors++; $display("FAIL rst_valid got=%b busy=%b exp=0000/0", out_valid, busy);
            end
            checks++;
            if ({dout0, dout1, dout2, dout3} !== 32'h0) begin
                errors++; $display("FAIL rst_dout got=%h exp=0", {dout0, dout1, dout2, dout3});
            end
        end
        reset_n = 1'b1;
        tick();
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0100 || dout2 !== 8'hA5 || busy !== 1'b1) begin
            errors++; $display("FAIL route got v=%b d2=%h busy=%b exp v=0100 d2=a5 busy=1", out_valid, dout2, busy);
        end
        drain_all();
    endtask

    task automatic test_fill_stall();
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_data = 8'h33;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full got=%b exp=0", in_ready); end
        in_sel = 2'd3;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL retarget got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b1010 || dout1 !== 8'h11 || dout3 !== 8'h33) begin
            errors++; $display("FAIL fill got v=%b d1=%h d3=%h exp v=1010 d1=11 d3=33", out_valid, dout1, dout3);
        end
        out_ready = 4'b0010;
        tick();
        out_ready = 4'h0;
        #1;
        checks++;
        if (dout1 !== 8'h22 || out_valid !== 4'b1010) begin
            errors++; $display("FAIL fill_order got v=%b d1=%h exp v=1010 d1=22", out_valid, dout1);
        end
        drain_all();
    endtask

    task automatic test_concurrent();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01;
        tick();
        in_data = 8'h02; out_ready = 4'b0001;
        #1;
        checks++;
        if (in_ready !== 1'b1 || dout0 !== 8'h01) begin
            errors++; $display("FAIL conc_pre got rdy=%b d0=%h exp rdy=1 d0=01", in_ready, dout0);
        end
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 4'b0001 || dout0 !== 8'h02) begin
            errors++; $display("FAIL conc_head got v=%b d0=%h exp v=0001 d0=02", out_valid, dout0);
        end
        out_ready = 4'b0001;
        tick();
        out_ready = 4'b0000;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL conc_drain got=%b exp=0", out_valid[0]); end
    endtask

    task automatic test_drain();
        logic [7:0] vals [8];
        vals = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1};
        out_ready = 4'h0;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_sel  = 2'(k / 2);
            in_data = vals[k];
            tick();
        end
        in_valid = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (out_valid[p] !== 1'b1 || dout_a[p] !== vals[2*p+b]) begin
                    errors++;
                    $display("FAIL drain_p%0d_b%0d got v=%b d=%h exp v=1 d=%h", p, b, out_valid[p], dout_a[p], vals[2*p+b]);
                end
            end
            out_ready = 4'hF;
            tick();
        end
        out_ready = 4'h0;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL drain_end got v=%b busy=%b exp 0000/0", out_valid, busy);
        end
    endtask

    task automatic test_flush_reset();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55;
        tick();
        in_sel = 2'd2; in_data = 8'h66;
        tick();
        flush = 1'b1; in_sel = 2'd1; in_data = 8'h77;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_clear got v=%b busy=%b exp 0000/0", out_valid, busy);
        end
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h99;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b1000 || dout3 !== 8'h99) begin
            errors++; $display("FAIL refill got v=%b d3=%h exp v=1000 d3=99", out_valid, dout3);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || dout3 !== 8'h00) begin
            errors++; $display("FAIL async_rst got v=%b busy=%b d3=%h exp 0000/0/00", out_valid, busy, dout3);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] q [4][$];
        logic [3:0] exp_v;
        logic       exp_rdy;
        logic       rdy_hold;
        int         sz;
        for (int p = 0; p < 4; p++) q[p].delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            flush     = ((cyc % 500) == 499);
            #1;
            exp_v = 4'b0;
            for (int p = 0; p < 4; p++) exp_v[p] = (q[p].size() != 0);
            sz = q[in_sel].size();
            exp_rdy = (sz != 2) && !flush;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
            end
            checks++;
            if (out_valid !== exp_v || busy !== (|exp_v)) begin
                errors++; $display("FAIL rnd_valid cyc=%0d got=%b busy=%b exp=%b", cyc, out_valid, busy, exp_v);
            end
            for (int p = 0; p < 4; p++) begin
                if (q[p].size() != 0) begin
                    checks++;
                    if (dout_a[p] !== q[p][0]) begin
                        errors++; $display("FAIL rnd_data cyc=%0d p=%0d got=%h exp=%h", cyc, p, dout_a[p], q[p][0]);
                    end
                end
            end
            rdy_hold  = in_ready;
            out_ready = ~out_ready;
            #1;
            checks++;
            if (in_ready !== rdy_hold) begin
                errors++; $display("FAIL rnd_isolation cyc=%0d got=%b exp=%b", cyc, in_ready, rdy_hold);
            end
            out_ready = ~out_ready;
            #1;
            if (flush) begin
                for (int p = 0; p < 4; p++) q[p].delete();
            end else begin
                for (int p = 0; p < 4; p++) begin
                    if (q[p].size() != 0 && out_ready[p]) void'(q[p].pop_front());
                end
                if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        drain_all();
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_concurrent();
        test_drain();
        test_flush_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
